// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter sharing the data-side slave bus between two masters,
// with registered grant, bounded burst lock and registered read-data return.

module bus_arbiter_checker (
  input logic clk,
  input logic reset,
  input logic m0_gnt,
  input logic m1_gnt,
  input logic m0_rvalid,
  input logic m1_rvalid
);

  // Protocol properties of the arbiter outputs
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(m0_gnt && m1_gnt)) else $error("both grants high");
    end
  end

  a_m0_rvalid_follows: assert property (@(posedge clk) disable iff (reset) m0_gnt |=> m0_rvalid);
  a_m1_rvalid_follows: assert property (@(posedge clk) disable iff (reset) m1_gnt |=> m1_rvalid);

endmodule

module bus_arbiter #(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK);

  owner_e      owner_q, owner_d;
  logic        last_q, last_d;          // 1'b0: M0 was last owner, 1'b1: M1
  logic [3:0]  lock_cnt_q, lock_cnt_d;
  logic        m0_rvalid_q, m0_rvalid_d;
  logic        m1_rvalid_q, m1_rvalid_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic        m0_gnt_s, m1_gnt_s;
  logic        m0_eff_s, m1_eff_s;
  logic        owner_lock_s;

  assign m0_gnt_s = (owner_q == OWN_M0);
  assign m1_gnt_s = (owner_q == OWN_M1);

  // A request seen during its own unlocked grant cycle is the access already on the bus.
  assign m0_eff_s = m0_req & ~(m0_gnt_s & ~m0_lock);
  assign m1_eff_s = m1_req & ~(m1_gnt_s & ~m1_lock);

  // Current owner's lock request
  always_comb begin
    owner_lock_s = 1'b0;
    case (owner_q)
      OWN_M0:  owner_lock_s = m0_lock;
      OWN_M1:  owner_lock_s = m1_lock;
      default: owner_lock_s = 1'b0;
    endcase
  end

  // Next-owner decision, round-robin pointer and lock counter
  always_comb begin
    owner_d    = OWN_NONE;
    last_d     = last_q;
    lock_cnt_d = 4'd0;

    if (m0_eff_s && m1_eff_s) begin
      if ((owner_q == OWN_M0) && m0_lock && (lock_cnt_q < LOCK_LIMIT)) begin
        owner_d = OWN_M0;
      end else if ((owner_q == OWN_M1) && m1_lock && (lock_cnt_q < LOCK_LIMIT)) begin
        owner_d = OWN_M1;
      end else if (last_q) begin
        owner_d = OWN_M0;
      end else begin
        owner_d = OWN_M1;
      end
    end else if (m0_eff_s) begin
      owner_d = OWN_M0;
    end else if (m1_eff_s) begin
      owner_d = OWN_M1;
    end else begin
      owner_d = OWN_NONE;
    end

    case (owner_d)
      OWN_M0:  last_d = 1'b0;
      OWN_M1:  last_d = 1'b1;
      default: last_d = last_q;
    endcase

    // Counting only runs while the other master is being held off by a lock.
    if (m0_eff_s && m1_eff_s && (owner_d == owner_q) && (owner_d != OWN_NONE) && owner_lock_s) begin
      if (lock_cnt_q < LOCK_LIMIT) begin
        lock_cnt_d = lock_cnt_q + 4'd1;
      end else begin
        lock_cnt_d = lock_cnt_q;
      end
    end else begin
      lock_cnt_d = 4'd0;
    end
  end

  // Response capture for the master owning the bus this cycle
  always_comb begin
    m0_rvalid_d = m0_gnt_s;
    m1_rvalid_d = m1_gnt_s;
    if (m0_gnt_s) begin
      m0_rdata_d = bus_rdata;
    end else begin
      m0_rdata_d = m0_rdata_q;
    end
    if (m1_gnt_s) begin
      m1_rdata_d = bus_rdata;
    end else begin
      m1_rdata_d = m1_rdata_q;
    end
  end

  // Arbitration and response state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      last_q      <= 1'b1;
      lock_cnt_q  <= 4'd0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= 32'h0000_0000;
      m1_rdata_q  <= 32'h0000_0000;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      lock_cnt_q  <= lock_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  // Bus mux follows the registered owner; an idle bus carries no write
  always_comb begin
    bus_addr   = 32'h0000_0000;
    bus_wdata  = 32'h0000_0000;
    bus_byteen = 4'h0;
    case (owner_q)
      OWN_M0: begin
        bus_addr   = m0_addr;
        bus_wdata  = m0_wdata;
        bus_byteen = m0_byteen;
      end
      OWN_M1: begin
        bus_addr   = m1_addr;
        bus_wdata  = m1_wdata;
        bus_byteen = m1_byteen;
      end
      default: begin
        bus_addr   = 32'h0000_0000;
        bus_wdata  = 32'h0000_0000;
        bus_byteen = 4'h0;
      end
    endcase
  end

  assign m0_gnt    = m0_gnt_s;
  assign m1_gnt    = m1_gnt_s;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

  bus_arbiter_checker u_checker (
    .clk       (clk),
    .reset     (reset),
    .m0_gnt    (m0_gnt_s),
    .m1_gnt    (m1_gnt_s),
    .m0_rvalid (m0_rvalid_q),
    .m1_rvalid (m1_rvalid_q)
  );

endmodule
